// File: rtl/sprite_blit_ctrl.sv
// rtl/sprite_blit_ctrl.sv - copies one sprite from a combinational ROM into the framebuffer
// Row-major scan with optional horizontal mirror, colour-key transparency and screen-edge clipping.
module sprite_blit_ctrl #(
   parameter int          SCREEN_W    = 640,
   parameter int          SCREEN_H    = 480,
   parameter int          FB_AW       = 19,
   parameter logic [15:0] TRANSPARENT = 16'hFFFF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [9:0]       pos_x,
   input  logic [8:0]       pos_y,
   input  logic             flip_h,
   output logic             busy,
   output logic             done,
   output logic [11:0]      pix_written,
   output logic [16:0]      spr_pixel,
   input  logic [15:0]      spr_color,
   input  logic [5:0]       spr_width,
   input  logic [5:0]       spr_height,
   output logic [FB_AW-1:0] fb_addr,
   output logic [15:0]      fb_data,
   output logic             fb_we,
   input  logic             fb_ready
);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

   localparam logic [10:0] SCR_W = 11'(SCREEN_W);
   localparam logic [9:0]  SCR_H = 10'(SCREEN_H);

   state_t      state;
   logic [9:0]  px;
   logic [8:0]  py;
   logic        flip;
   logic [5:0]  w;
   logic [5:0]  h;
   logic [5:0]  col;
   logic [5:0]  row;
   logic [16:0] row_base;

   logic [10:0]      sx;
   logic [9:0]       sy;
   logic             advance;
   logic             last_col;
   logic             last_row;
   logic             visible;
   logic [5:0]       ncol;
   logic [5:0]       nrow;
   logic [16:0]      nbase;
   logic [5:0]       nidx;
   logic [FB_AW-1:0] addr_calc;

   assign sx        = {1'b0, px} + {5'b0, col};
   assign sy        = {1'b0, py} + {4'b0, row};
   assign advance   = !fb_we || fb_ready;
   assign last_col  = (col == w - 6'd1);
   assign last_row  = (row == h - 6'd1);
   assign visible   = (spr_color != TRANSPARENT) && (sx < SCR_W) && (sy < SCR_H);
   assign addr_calc = FB_AW'(sy) * FB_AW'(SCREEN_W) + FB_AW'(sx);

   // Next texel position; spr_pixel is registered so the ROM sees it one cycle ahead of use.
   always_comb begin
      ncol  = last_col ? 6'd0 : col + 6'd1;
      nrow  = last_col ? row + 6'd1 : row;
      nbase = last_col ? row_base + {11'b0, w} : row_base;
      nidx  = flip ? (w - 6'd1 - ncol) : ncol;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         pix_written <= '0;
         spr_pixel   <= '0;
         fb_addr     <= '0;
         fb_data     <= '0;
         fb_we       <= 1'b0;
         px          <= '0;
         py          <= '0;
         flip        <= 1'b0;
         w           <= '0;
         h           <= '0;
         col         <= '0;
         row         <= '0;
         row_base    <= '0;
      end else begin
         if (fb_we && fb_ready && pix_written != 12'hFFF)
            pix_written <= pix_written + 12'd1;

         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  px          <= pos_x;
                  py          <= pos_y;
                  flip        <= flip_h;
                  w           <= spr_width;
                  h           <= spr_height;
                  col         <= '0;
                  row         <= '0;
                  row_base    <= '0;
                  pix_written <= '0;
                  busy        <= 1'b1;
                  spr_pixel   <= flip_h ? {11'b0, spr_width - 6'd1} : 17'd0;
                  if (spr_width == 6'd0 || spr_height == 6'd0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= SCAN;
                  end
               end
            end
            SCAN: begin
               if (advance) begin
                  fb_we <= visible;
                  if (visible) begin
                     fb_data <= spr_color;
                     fb_addr <= addr_calc;
                  end
                  col       <= ncol;
                  row       <= nrow;
                  row_base  <= nbase;
                  spr_pixel <= nbase + {11'b0, nidx};
                  if (last_col && last_row)
                     state <= DRAIN;
               end
            end
            DRAIN: begin
               if (advance) begin
                  fb_we <= 1'b0;
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_blit_ctrl.sv
// tb/tb_sprite_blit_ctrl.sv - scoreboard bench for sprite_blit_ctrl with a behavioural blit model
module tb_sprite_blit_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [9:0]  pos_x = '0;
   logic [8:0]  pos_y = '0;
   logic        flip_h = 1'b0;
   logic        busy, done, fb_we;
   logic [11:0] pix_written;
   logic [16:0] spr_pixel;
   logic [15:0] spr_color;
   logic [5:0]  spr_width = '0;
   logic [5:0]  spr_height = '0;
   logic [18:0] fb_addr;
   logic [15:0] fb_data;
   logic        fb_ready = 1'b1;

   logic [15:0] rom [0:4095];
   logic [34:0] sb [$];
   int          n_checks = 0;
   int          n_pass = 0;
   int          cyc = 0;
   int          rmode = 0;
   int          lo_s = -1;
   int          lo_e = -1;

   sprite_blit_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .pos_x(pos_x), .pos_y(pos_y), .flip_h(flip_h),
      .busy(busy), .done(done), .pix_written(pix_written), .spr_pixel(spr_pixel),
      .spr_color(spr_color), .spr_width(spr_width), .spr_height(spr_height),
      .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .fb_ready(fb_ready)
   );

   assign spr_color = (spr_pixel < 17'd4096) ? rom[spr_pixel[11:0]] : 16'h0000;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      case (rmode)
         1:       fb_ready = ($urandom_range(0, 3) != 0);
         2:       fb_ready = !(cyc >= lo_s && cyc <= lo_e);
         default: fb_ready = 1'b1;
      endcase
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   always @(negedge clk) begin
      if (!rst && fb_we && fb_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_write: got addr %0d data %0h, expected no write", fb_addr, fb_data);
         end else begin
            logic [34:0] e;
            e = sb.pop_front();
            check("fb_addr", fb_addr, e[34:16]);
            check("fb_data", fb_data, e[15:0]);
         end
      end
   end

   // Reference: every texel in row-major order, mirrored lookup, keep it if opaque and on-screen.
   task automatic model(input int x, input int y, input bit f, input int w, input int h,
                        output int cnt, output int seq [$]);
      cnt = 0;
      seq.delete();
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            int idx, sx, sy;
            logic [15:0] colr;
            idx  = r * w + (f ? (w - 1 - c) : c);
            seq.push_back(idx);
            colr = rom[idx];
            sx   = x + c;
            sy   = y + r;
            if (colr != 16'hFFFF && sx < 640 && sy < 480) begin
               sb.push_back({19'(sy * 640 + sx), colr});
               cnt++;
            end
         end
      end
   endtask

   task automatic blit(input int x, input int y, input bit f, input int w, input int h,
                       input int rm, input int stall_n, input int done_off, input bit chk_seq);
      int seq [$];
      int cnt, n, t, c, dcyc;
      bit found;
      logic [34:0] first;
      model(x, y, f, w, h, cnt, seq);
      n = w * h;
      first = (sb.size() > 0) ? sb[0] : '0;
      @(posedge clk);
      #1;
      t          = cyc;
      pos_x      = 10'(x);
      pos_y      = 9'(y);
      flip_h     = f;
      spr_width  = 6'(w);
      spr_height = 6'(h);
      start      = 1'b1;
      rmode      = (stall_n > 0) ? 2 : rm;
      lo_s       = t + 2;
      lo_e       = t + 1 + stall_n;
      @(posedge clk);
      #1;
      start = 1'b0;
      found = 0;
      dcyc  = 0;
      for (int k = 0; k < 3000 && !found; k++) begin
         @(negedge clk);
         c = cyc - t;
         if (chk_seq && c >= 1 && c <= n) check("spr_pixel_seq", spr_pixel, seq[c-1]);
         if (stall_n > 0 && c >= 2 && c <= 1 + stall_n) begin
            check("stall_we", fb_we, 1);
            check("stall_addr", fb_addr, first[34:16]);
            check("stall_data", fb_data, first[15:0]);
            check("stall_pixel", spr_pixel, seq[1]);
         end
         if (done) begin
            found = 1;
            dcyc  = c;
         end
      end
      if (!found) begin
         n_checks++;
         $display("FAIL done_timeout: got no done, expected done within 3000 cycles");
      end else if (done_off >= 0) begin
         check("done_cycle", dcyc, done_off);
      end
      check("sb_empty", sb.size(), 0);
      check("pix_written", pix_written, cnt);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("busy_idle", busy, 0);
      rmode = 0;
      sb.delete();
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) rom[i] = 16'(i * 7 + 3);
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_we", fb_we, 0);
      check("rst_pixw", pix_written, 0);
      check("rst_pixel", spr_pixel, 0);
      check("rst_addr", fb_addr, 0);
      check("rst_data", fb_data, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 4; i++) rom[i] = 16'h1234;
      blit(10, 5, 0, 2, 2, 0, 0, 6, 1);
      rom[1] = 16'hFFFF;
      blit(10, 5, 0, 2, 2, 0, 0, 6, 1);
      rom[1] = 16'h1234;
      blit(10, 5, 0, 2, 2, 0, 3, 9, 0);
      blit(639, 479, 0, 2, 2, 0, 0, 6, 1);
      for (int i = 0; i < 6; i++) rom[i] = 16'(16'h0A00 + i);
      blit(100, 50, 1, 3, 2, 0, 0, 8, 1);
      blit(100, 50, 0, 0, 4, 0, 0, 1, 0);

      begin
         int cnt;
         int seq [$];
         model(0, 0, 0, 8, 8, cnt, seq);
         @(posedge clk);
         #1;
         pos_x = 0; pos_y = 0; flip_h = 0; spr_width = 8; spr_height = 8; start = 1'b1;
         @(posedge clk);
         #1 start = 1'b0;
         repeat (5) @(posedge clk);
         #1 rst = 1'b1;
         @(posedge clk);
         #1 rst = 1'b0;
         sb.delete();
         @(negedge clk);
         check("abort_busy", busy, 0);
         check("abort_we", fb_we, 0);
         check("abort_done", done, 0);
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
         end
      end
      blit(20, 30, 0, 3, 3, 0, 0, 11, 1);

      for (int i = 0; i < 4096; i++) rom[i] = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
      for (int b = 0; b < 25; b++) begin
         int x, y;
         x = ($urandom_range(0, 1) == 1) ? $urandom_range(600, 1023) : $urandom_range(0, 599);
         y = ($urandom_range(0, 1) == 1) ? $urandom_range(440, 511) : $urandom_range(0, 439);
         blit(x, y, 1'($urandom_range(0, 1)), $urandom_range(0, 12), $urandom_range(0, 12),
              1, 0, -1, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sprite_blit_ctrl.md
Name: sprite_blit_ctrl

Overview:
- Sequences a combinational sprite ROM (17-bit pixel index in; 16-bit RGB565 colour, 6-bit width and height out) and copies one sprite into the framebuffer at a given screen position.
- Scans the sprite in row-major order and optionally mirrors it horizontally.
- Skips transparent texels and clips to the screen edge.
- Issues framebuffer writes over a valid/ready handshake. It sits between the game/overworld logic and the framebuffer write port.

Parameters:
- SCREEN_W, 640, screen width in pixels.
- SCREEN_H, 480, screen height in pixels.
- FB_AW, 19, framebuffer address width.
- TRANSPARENT, 16'hFFFF, colour key; texels of this colour are not written.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request to blit one sprite; sampled only in IDLE.
- pos_x  in  10  screen x of the sprite's top-left corner.
- pos_y  in  9  screen y of the sprite's top-left corner.
- flip_h  in  1  mirror the sprite horizontally.
- busy  out  1  high while state != IDLE.
- done  out  1  one-cycle pulse when the blit completes.
- pix_written  out  12  count of framebuffer writes accepted in the current or last blit.
- spr_pixel  out  17  pixel index driven to the sprite ROM.
- spr_color  in  16  ROM colour for spr_pixel; combinational, same cycle.
- spr_width  in  6  sprite width; latched on start.
- spr_height  in  6  sprite height; latched on start.
- fb_addr  out  FB_AW  framebuffer write address.
- fb_data  out  16  framebuffer write data.
- fb_we  out  1  write valid.
- fb_ready  in  1  framebuffer accepts the write when fb_we && fb_ready.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset state: state=IDLE. busy, done, fb_we and pix_written are 0. spr_pixel, fb_addr and fb_data are 0.
- Reset mid-blit aborts the blit with no done pulse; fb_we drops at the edge.
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - On start, latch pos_x, pos_y, flip_h, spr_width (w) and spr_height (h); clear pix_written; col=0, row=0, row_base=0.
  - If w==0 or h==0, go to DONE with no writes. Otherwise go to SCAN.
- SCAN:
  - spr_pixel = row_base + (flip ? w-1-col : col), zero-extended to 17 bits. row_base accumulates w per row, so it equals row*w; no multiplier is required.
  - sx = pos_x + col and sy = pos_y + row, computed at 11 and 10 bits so they do not wrap.
  - A texel "advances" when the output register is free or being accepted, i.e. !fb_we || fb_ready.
  - On advance: if spr_color != TRANSPARENT and sx < SCREEN_W and sy < SCREEN_H, load fb_we=1, fb_data=spr_color and fb_addr=sy*SCREEN_W+sx. Otherwise load fb_we=0.
  - Then col++. When col==w-1, set col=0, row++ and row_base += w.
  - When the last texel (row==h-1, col==w-1) advances, go to DRAIN.
  - While stalled (fb_we && !fb_ready), col, row, spr_pixel, fb_addr and fb_data are held stable.
- DRAIN: wait until !fb_we or fb_ready, clearing fb_we on acceptance, then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy is still 1 in DONE.
- pix_written increments on every fb_we && fb_ready cycle and saturates at 4095. It holds its value after done until the next start.
- start while busy is ignored.
- Throughput: one texel per cycle while fb_ready=1.
- Timing for an unstalled blit of N=w*h texels with start at cycle T:
  - SCAN covers T+1..T+N.
  - Writes are valid T+2..T+N+1.
  - DRAIN is at T+N+1, done at T+N+2, and IDLE (busy=0) at T+N+3.
  - Each fb_ready-low cycle adds one cycle to this timing.

Test Plan:
- 2x2 all-opaque sprite (0x1234), pos (10,5), fb_ready=1, start at T -> fb_addr 3210, 3211, 3850, 3851 at T+2..T+5; done at T+6; pix_written=4.
- 2x2 sprite with texel 1 = 16'hFFFF -> only addresses 3210, 3850, 3851 are written, no gap-filling; pix_written=3; done still at T+6.
- Same as the first case with fb_ready low for 3 cycles at the first write -> fb_addr=3210 and fb_data stay stable and spr_pixel holds at 1; done at T+9.
- Clipping: pos (639,479), 2x2 opaque -> a single write at addr 307199; pix_written=1; done is asserted.
- flip_h=1, w=3, h=2 -> spr_pixel sequence 2,1,0,5,4,3, and texel 2 lands at sx=pos_x.
- Zero and reset cases:
  - w=0 start -> done at T+1 with no fb_we.
  - rst asserted during SCAN of an 8x8 sprite -> next cycle busy=0, fb_we=0, no done.
  - A following start blits normally.
